// File: rtl/ct_vfalu_pipe_vld_ctrl.sv
// rtl/ct_vfalu_pipe_vld_ctrl.sv - valid/pipedown controller for one VFALU execution pipe
//
// Tracks op valids through EX1..EX<STAGES>, with flush, optional hold,
// an in-flight counter and idle/clock-request outputs.
//
// Optional feature macro: CT_VFALU_PIPE_STALL_EN
//   defined   : pipe_stall holds every registered stage, ex1_issue_rdy = !pipe_stall
//   undefined : pipe_stall ignored, ex1_issue_rdy tied 1
//
// Ports:
//   ex1_vld_clk            in   gated clock for all state (ICG enable = vld_clk_en_req)
//   cpurst_b               in   async active-low reset
//   dp_vfalu_ex1_pipex_sel in   [SEL_W] dispatch pipe select, bit PIPE_IDX issues here
//   rtu_vfpu_flush         in   kill all in-flight ops, including the current issue
//   pipe_stall             in   hold request (only with CT_VFALU_PIPE_STALL_EN)
//   ex_pipedown            out  [STAGES] bit k = op valid in EX(k+1); bit 0 combinational
//   ex_pipe_clk_en         out  [STAGES] bit k = stage k data advances this cycle
//   ex_retire              out  last-stage op leaves the pipe this cycle
//   inflight_cnt           out  [CNT_W] valid ops in the registered stages
//   pipe_idle              out  no valid op in any stage
//   vld_clk_en_req         out  local enable for the ex1_vld_clk ICG
//   ex1_issue_rdy          out  pipe can accept an EX1 issue

module ct_vfalu_pipe_vld_ctrl #(
  parameter int STAGES   = 3,
  parameter int SEL_W    = 3,
  parameter int PIPE_IDX = 1,
  parameter int CNT_W    = 4
) (
  input  logic              ex1_vld_clk,
  input  logic              cpurst_b,
  input  logic [SEL_W-1:0]  dp_vfalu_ex1_pipex_sel,
  input  logic              rtu_vfpu_flush,
  input  logic              pipe_stall,
  output logic [STAGES-1:0] ex_pipedown,
  output logic [STAGES-1:0] ex_pipe_clk_en,
  output logic              ex_retire,
  output logic [CNT_W-1:0]  inflight_cnt,
  output logic              pipe_idle,
  output logic              vld_clk_en_req,
  output logic              ex1_issue_rdy
);

  logic              stall_eff;
  logic              ex1_vld;
  logic [STAGES-1:1] vld_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_inc;
  logic              cnt_dec;
  logic              adv_en;

`ifdef CT_VFALU_PIPE_STALL_EN
  assign stall_eff = pipe_stall;
`else
  assign stall_eff = 1'b0;
`endif

  // Select bits for other pipes (and pipe_stall when the hold path is
  // compiled out) are intentionally not consumed by this pipe.
  logic unused_inputs;
  assign unused_inputs = ^{dp_vfalu_ex1_pipex_sel, pipe_stall};

  // A flush in the issue cycle kills the incoming op as well.
  assign ex1_vld     = dp_vfalu_ex1_pipex_sel[PIPE_IDX] & ~rtu_vfpu_flush;
  assign ex_pipedown = {vld_q, ex1_vld};

  // Data only moves when neither held nor flushed; a stalled EX1 select is
  // dropped because stage 1 holds.
  assign adv_en         = ~stall_eff & ~rtu_vfpu_flush;
  assign ex_pipe_clk_en = ex_pipedown & {STAGES{adv_en}};
  assign ex_retire      = ex_pipe_clk_en[STAGES-1];

  assign cnt_inc = ex1_vld & ~stall_eff;
  assign cnt_dec = ex_retire;

  always_ff @(posedge ex1_vld_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else if (rtu_vfpu_flush) begin
      vld_q <= '0;
      cnt_q <= '0;
    end else if (!stall_eff) begin
      vld_q <= ex_pipedown[STAGES-2:0];
      cnt_q <= cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
    end
  end

  assign inflight_cnt  = cnt_q;
  assign pipe_idle     = ~(|ex_pipedown);
  // Flush keeps the clock running for the edge that clears the stages.
  assign vld_clk_en_req = (|ex_pipedown) | rtu_vfpu_flush;
  assign ex1_issue_rdy  = ~stall_eff;

endmodule

// File: tb/tb_ct_vfalu_pipe_vld_ctrl.sv
// tb/tb_ct_vfalu_pipe_vld_ctrl.sv - self-checking bench for ct_vfalu_pipe_vld_ctrl
module tb_ct_vfalu_pipe_vld_ctrl;

  localparam int STAGES = 3;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              cpurst_b;
  logic [2:0]        sel;
  logic              flush;
  logic              stall;
  logic [STAGES-1:0] ex_pipedown;
  logic [STAGES-1:0] ex_pipe_clk_en;
  logic              ex_retire;
  logic [CNT_W-1:0]  inflight_cnt;
  logic              pipe_idle;
  logic              vld_clk_en_req;
  logic              ex1_issue_rdy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int q[$];

  ct_vfalu_pipe_vld_ctrl #(
    .STAGES(STAGES), .SEL_W(3), .PIPE_IDX(1), .CNT_W(CNT_W)
  ) dut (
    .ex1_vld_clk(clk),
    .cpurst_b(cpurst_b),
    .dp_vfalu_ex1_pipex_sel(sel),
    .rtu_vfpu_flush(flush),
    .pipe_stall(stall),
    .ex_pipedown(ex_pipedown),
    .ex_pipe_clk_en(ex_pipe_clk_en),
    .ex_retire(ex_retire),
    .inflight_cnt(inflight_cnt),
    .pipe_idle(pipe_idle),
    .vld_clk_en_req(vld_clk_en_req),
    .ex1_issue_rdy(ex1_issue_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard pop on retire, occupancy invariant and issue protocol.
  always @(negedge clk) begin
    checks++;
    if (inflight_cnt !== CNT_W'($countones(ex_pipedown[STAGES-1:1]))) begin
      errors++;
      $display("FAIL cnt_invariant cyc=%0d got %0d want %0d", cyc, inflight_cnt,
               $countones(ex_pipedown[STAGES-1:1]));
    end
    if (ex_retire === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_retire cyc=%0d got 1 want 0", cyc);
      end else begin
        if (q[0] != cyc) begin
          errors++;
          $display("FAIL sb_retire_cycle got %0d want %0d", cyc, q[0]);
        end
        void'(q.pop_front());
      end
    end else if (q.size() > 0 && q[0] <= cyc) begin
      checks++;
      errors++;
      $display("FAIL sb_missing_retire cyc=%0d got 0 want 1", cyc);
      void'(q.pop_front());
    end
    if (sel[1] && !ex1_issue_rdy) begin
      errors++;
      $display("FAIL protocol_issue_when_not_rdy cyc=%0d", cyc);
    end
  end

  task automatic cyc_in(input logic [2:0] s, input logic f, input logic st);
    @(posedge clk);
    #1;
    sel = s; flush = f; stall = st;
    if (f) q.delete();
    else begin
`ifdef CT_VFALU_PIPE_STALL_EN
      if (st) begin
        foreach (q[i]) q[i] = q[i] + 1;
      end else if (s[1]) q.push_back(cyc + STAGES - 1);
`else
      if (s[1]) q.push_back(cyc + STAGES - 1);
`endif
    end
  endtask

  task automatic test_reset();
    cpurst_b = 1'b0; sel = 3'b000; flush = 1'b0; stall = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ex_pipedown !== 3'b000 || inflight_cnt !== 4'd0 || pipe_idle !== 1'b1 ||
        ex_retire !== 1'b0 || ex_pipe_clk_en !== 3'b000 || vld_clk_en_req !== 1'b0 ||
        ex1_issue_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_values got pd=%b cnt=%0d idle=%b ret=%b en=%b req=%b rdy=%b want 000 0 1 0 000 0 1",
               ex_pipedown, inflight_cnt, pipe_idle, ex_retire, ex_pipe_clk_en, vld_clk_en_req, ex1_issue_rdy);
    end
    cpurst_b = 1'b1;
  endtask

  task automatic test_single();
    logic [2:0] e_pd [4] = '{3'b001, 3'b010, 3'b100, 3'b000};
    logic [3:0] e_cnt[4] = '{4'd0, 4'd1, 4'd1, 4'd0};
    logic       e_ret[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc_in((i == 0) ? 3'b010 : 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (ex_pipedown !== e_pd[i] || inflight_cnt !== e_cnt[i] || ex_retire !== e_ret[i] ||
          pipe_idle !== (e_pd[i] == 3'b000) || ex_pipe_clk_en !== e_pd[i]) begin
        errors++;
        $display("FAIL single[%0d] got pd=%b cnt=%0d ret=%b idle=%b en=%b want pd=%b cnt=%0d ret=%b",
                 i, ex_pipedown, inflight_cnt, ex_retire, pipe_idle, ex_pipe_clk_en, e_pd[i], e_cnt[i], e_ret[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e_pd [7] = '{3'b001, 3'b011, 3'b111, 3'b111, 3'b110, 3'b100, 3'b000};
    logic [3:0] e_cnt[7] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
    logic       e_ret[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      cyc_in((i < 4) ? 3'b010 : 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (ex_pipedown !== e_pd[i] || inflight_cnt !== e_cnt[i] || ex_retire !== e_ret[i]) begin
        errors++;
        $display("FAIL b2b[%0d] got pd=%b cnt=%0d ret=%b want pd=%b cnt=%0d ret=%b",
                 i, ex_pipedown, inflight_cnt, ex_retire, e_pd[i], e_cnt[i], e_ret[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [2:0] e_pd [5] = '{3'b001, 3'b011, 3'b111, 3'b110, 3'b000};
    logic [3:0] e_cnt[5] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd0};
    logic       e_ret[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0] e_en [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b000};
    logic       e_req[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      cyc_in((i < 4) ? 3'b010 : 3'b000, (i == 3), 1'b0);
      @(negedge clk);
      checks++;
      if (ex_pipedown !== e_pd[i] || inflight_cnt !== e_cnt[i] || ex_retire !== e_ret[i] ||
          ex_pipe_clk_en !== e_en[i] || vld_clk_en_req !== e_req[i]) begin
        errors++;
        $display("FAIL flush[%0d] got pd=%b cnt=%0d ret=%b en=%b req=%b want pd=%b cnt=%0d ret=%b en=%b req=%b",
                 i, ex_pipedown, inflight_cnt, ex_retire, ex_pipe_clk_en, vld_clk_en_req,
                 e_pd[i], e_cnt[i], e_ret[i], e_en[i], e_req[i]);
      end
    end
    cyc_in(3'b000, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
`ifdef CT_VFALU_PIPE_STALL_EN
    logic [2:0] e_pd [7] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b000};
    logic [3:0] e_cnt[7] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd0};
    logic       e_ret[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       e_rdy[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [2:0] e_en [7] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b100, 3'b000};
`else
    logic [2:0] e_pd [7] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
    logic [3:0] e_cnt[7] = '{4'd0, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    logic       e_ret[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       e_rdy[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] e_en [7] = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
    for (int i = 0; i < 7; i++) begin
      cyc_in((i == 0) ? 3'b010 : 3'b000, 1'b0, (i >= 1 && i <= 3));
      @(negedge clk);
      checks++;
      if (ex_pipedown !== e_pd[i] || inflight_cnt !== e_cnt[i] || ex_retire !== e_ret[i] ||
          ex1_issue_rdy !== e_rdy[i] || ex_pipe_clk_en !== e_en[i]) begin
        errors++;
        $display("FAIL stall[%0d] got pd=%b cnt=%0d ret=%b rdy=%b en=%b want pd=%b cnt=%0d ret=%b rdy=%b en=%b",
                 i, ex_pipedown, inflight_cnt, ex_retire, ex1_issue_rdy, ex_pipe_clk_en,
                 e_pd[i], e_cnt[i], e_ret[i], e_rdy[i], e_en[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
`ifdef CT_VFALU_PIPE_STALL_EN
    logic [2:0] e_pd [10] = '{3'b001, 3'b011, 3'b110, 3'b000, 3'b001, 3'b011, 3'b110, 3'b110, 3'b100, 3'b000};
    logic       e_ret[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] e_cnt[10] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd1, 4'd2, 4'd2, 4'd1, 4'd0};
`else
    logic [2:0] e_pd [10] = '{3'b001, 3'b011, 3'b110, 3'b000, 3'b001, 3'b011, 3'b110, 3'b100, 3'b000, 3'b000};
    logic       e_ret[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] e_cnt[10] = '{4'd0, 4'd1, 4'd2, 4'd0, 4'd0, 4'd1, 4'd2, 4'd1, 4'd0, 4'd0};
`endif
    for (int i = 0; i < 10; i++) begin
      cyc_in((i == 0 || i == 1 || i == 4 || i == 5) ? 3'b010 : 3'b000, (i == 2), (i == 2 || i == 6));
      @(negedge clk);
      checks++;
      if (ex_pipedown !== e_pd[i] || inflight_cnt !== e_cnt[i] || ex_retire !== e_ret[i]) begin
        errors++;
        $display("FAIL stall_flush[%0d] got pd=%b cnt=%0d ret=%b want pd=%b cnt=%0d ret=%b",
                 i, ex_pipedown, inflight_cnt, ex_retire, e_pd[i], e_cnt[i], e_ret[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) cyc_in(3'b010, 1'b0, 1'b0);
    @(negedge clk);
    checks++;
    if (ex_pipedown !== 3'b111) begin
      errors++;
      $display("FAIL rst_mid_fill got %b want 111", ex_pipedown);
    end
    @(posedge clk);
    #2;
    cpurst_b = 1'b0; sel = 3'b000;
    q.delete();
    #1;
    checks++;
    if (ex_pipedown !== 3'b000 || inflight_cnt !== 4'd0 || ex_retire !== 1'b0 ||
        pipe_idle !== 1'b1 || ex_pipe_clk_en !== 3'b000 || vld_clk_en_req !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async got pd=%b cnt=%0d ret=%b idle=%b en=%b req=%b want 000 0 0 1 000 0",
               ex_pipedown, inflight_cnt, ex_retire, pipe_idle, ex_pipe_clk_en, vld_clk_en_req);
    end
    @(negedge clk);
    cpurst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc_in((i < 2) ? 3'b001 : 3'b000, 1'b0, 1'b0);
      @(negedge clk);
      checks++;
      if (ex_pipedown !== 3'b000 || pipe_idle !== 1'b1 || inflight_cnt !== 4'd0 || vld_clk_en_req !== 1'b0) begin
        errors++;
        $display("FAIL other_pipe[%0d] got pd=%b idle=%b cnt=%0d req=%b want 000 1 0 0",
                 i, ex_pipedown, pipe_idle, inflight_cnt, vld_clk_en_req);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_stall();
    test_stall_flush();
    test_reset_mid();
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
